// File: rtl/pipeline_hazard_pkg.sv
// pipeline_hazard_pkg: forwarding selects, divide FSM states and defaults shared by the hazard unit.
package pipeline_hazard_pkg;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W = 2'b01;
    localparam logic [1:0] FWD_M = 2'b10;
    localparam int DIV_MAX_CYCLES_DEF = 40;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} divState_t;

    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input logic wrM,
        input logic [4:0] regM,
        input logic wrW,
        input logic [4:0] regW
    );
        return (wrM && regM != 5'd0 && regM == src) ? FWD_M :
               (wrW && regW != 5'd0 && regW == src) ? FWD_W : FWD_RF;
    endfunction
endpackage

// File: rtl/pipeline_hazard_div_handshake.sv
// div_handshake: multi-cycle divider start/wait FSM with watchdog, driving the divide stall.
module div_handshake
    import pipeline_hazard_pkg::*;
#(
    parameter int MAX_CYCLES = DIV_MAX_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic divE,
    input  logic div_done,
    input  logic hold,
    input  logic abort,
    output logic divStart,
    output logic divStall
);
    localparam logic [5:0] LIMIT = 6'(MAX_CYCLES);

    divState_t state;
    logic [5:0] count;

    assign divStart = state == DIV_IDLE && divE && !hold && !abort;
    assign divStall = (state == DIV_IDLE && divE) || state == DIV_BUSY;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state <= DIV_IDLE;
            count <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (divStart) begin
                        state <= DIV_BUSY;
                        count <= '0;
                    end
                end
                DIV_BUSY: begin
                    count <= count + 6'd1;
                    if (div_done) state <= DIV_DONE;
                    else if (count == LIMIT) state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/pipeline_hazard.sv
// pipeline_hazard: stall/flush arbiter with operand and HI/LO forwarding for the five-stage core.
// Define HAZARD_HILO_FWD_EN to forward HI/LO writes instead of stalling on them.
module pipeline_hazard
    import pipeline_hazard_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = DIV_MAX_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeregE,
    input  logic [4:0] writeregM,
    input  logic [4:0] writeregW,
    input  logic       regwriteE,
    input  logic       regwriteM,
    input  logic       regwriteW,
    input  logic       memtoregE,
    input  logic       memtoregM,
    input  logic       branchD,
    input  logic       jalrD,
    input  logic       hiloreadE,
    input  logic       hilowriteM,
    input  logic       hilowriteW,
    input  logic       divE,
    input  logic       div_done,
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       exceptM,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic [1:0] forwardhiloE,
    output logic       div_start,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       stallW,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       flushW
);
    logic memStall, lwStall, branchStall, divStall, hiloStall;
    logic eHitsD, mHitsD, excFlush, excPending, divGo, run;
    logic [1:0] hiloFwd;

    assign memStall = i_stall | d_stall;
    assign lwStall = memtoregE & ((rtE == rsD) | (rtE == rtD));
    assign eHitsD = writeregE != 5'd0 && (writeregE == rsD || writeregE == rtD);
    assign mHitsD = writeregM != 5'd0 && (writeregM == rsD || writeregM == rtD);
    assign branchStall = (branchD | jalrD) & ((regwriteE & eHitsD) | (memtoregM & mHitsD));

`ifdef HAZARD_HILO_FWD_EN
    assign hiloStall = 1'b0;
    assign hiloFwd = hilowriteM ? FWD_M : hilowriteW ? FWD_W : FWD_RF;
`else
    assign hiloStall = hiloreadE & (hilowriteM | hilowriteW);
    assign hiloFwd = FWD_RF;
`endif

    // An exception held behind a data-memory stall is replayed on the first free cycle.
    assign excFlush = ~rst & (exceptM | excPending) & ~d_stall;

    always_ff @(posedge clk)
        excPending <= ~rst & (exceptM | excPending) & d_stall;

    div_handshake #(.MAX_CYCLES(DIV_MAX_CYCLES)) u_div (
        .clk(clk),
        .rst(rst),
        .divE(divE),
        .div_done(div_done),
        .hold(memStall | hiloStall),
        .abort(excFlush),
        .divStart(divGo),
        .divStall(divStall)
    );

    assign run = ~rst & ~excFlush;
    assign forwardAE = rst ? FWD_RF : fwdSel(rsE, regwriteM, writeregM, regwriteW, writeregW);
    assign forwardBE = rst ? FWD_RF : fwdSel(rtE, regwriteM, writeregM, regwriteW, writeregW);
    assign forwardAD = ~rst && regwriteM && rsD != 5'd0 && rsD == writeregM;
    assign forwardBD = ~rst && regwriteM && rtD != 5'd0 && rtD == writeregM;
    assign forwardhiloE = rst ? FWD_RF : hiloFwd;
    assign div_start = ~rst & divGo;
    assign stallF = run & (lwStall | branchStall | divStall | memStall | hiloStall);
    assign stallD = stallF;
    assign stallE = run & (divStall | memStall | hiloStall);
    assign stallM = run & memStall;
    assign stallW = stallM;
    assign flushD = excFlush;
    assign flushE = excFlush | (~rst & (lwStall | branchStall) & ~divStall & ~memStall);
    assign flushM = excFlush | (~rst & hiloStall);
    assign flushW = excFlush;
endmodule

// File: tb/tb_pipeline_hazard.sv
// tb_pipeline_hazard: directed scenarios then random traffic, every cycle checked against a reference model.
module tb_pipeline_hazard;
    localparam int LIMIT = 40;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jalrD;
    logic hiloreadE, hilowriteM, hilowriteW, divE, div_done, i_stall, d_stall, exceptM;
    logic forwardAD, forwardBD, div_start;
    logic [1:0] forwardAE, forwardBE, forwardhiloE;
    logic stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW;

    int nCmp = 0;
    int nErr = 0;
    bit mBusy, mDone, mPend;
    int mBusyCycles;

    always #5 clk = ~clk;

    pipeline_hazard dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .jalrD(jalrD),
        .hiloreadE(hiloreadE), .hilowriteM(hilowriteM), .hilowriteW(hilowriteW),
        .divE(divE), .div_done(div_done), .i_stall(i_stall), .d_stall(d_stall),
        .exceptM(exceptM),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardhiloE(forwardhiloE),
        .div_start(div_start),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW)
    );

    function automatic logic [1:0] fwd(input logic [4:0] r);
        if (regwriteM && writeregM != 0 && writeregM == r) return 2'b10;
        if (regwriteW && writeregW != 0 && writeregW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit usesD(input logic [4:0] r);
        return r != 0 && (r == rsD || r == rtD);
    endfunction

    function automatic bit hiloHold();
`ifdef HAZARD_HILO_FWD_EN
        return 1'b0;
`else
        return hiloreadE && (hilowriteM || hilowriteW);
`endif
    endfunction

    function automatic logic [1:0] hiloSel();
`ifdef HAZARD_HILO_FWD_EN
        return hilowriteM ? 2'b10 : hilowriteW ? 2'b01 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    function automatic bit exFlush();
        return !rst && (exceptM || mPend) && !d_stall;
    endfunction

    function automatic bit divStartExp();
        return !rst && !mBusy && !mDone && divE && !(i_stall || d_stall) && !hiloHold() && !exFlush();
    endfunction

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nErr++;
            $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic checkAll();
        bit on, mem, lw, br, dv, hs, ex;
        on = !rst;
        mem = i_stall || d_stall;
        lw = memtoregE && (rtE == rsD || rtE == rtD);
        br = (branchD || jalrD) && ((regwriteE && usesD(writeregE)) || (memtoregM && usesD(writeregM)));
        dv = (!mBusy && !mDone && divE) || mBusy;
        hs = hiloHold();
        ex = exFlush();
        chk("forwardAE", forwardAE, on ? fwd(rsE) : 2'b00);
        chk("forwardBE", forwardBE, on ? fwd(rtE) : 2'b00);
        chk("forwardAD", forwardAD, on && regwriteM && rsD != 0 && rsD == writeregM);
        chk("forwardBD", forwardBD, on && regwriteM && rtD != 0 && rtD == writeregM);
        chk("forwardhiloE", forwardhiloE, on ? hiloSel() : 2'b00);
        chk("div_start", div_start, divStartExp());
        chk("stallF", stallF, on && !ex && (lw || br || dv || mem || hs));
        chk("stallD", stallD, on && !ex && (lw || br || dv || mem || hs));
        chk("stallE", stallE, on && !ex && (dv || mem || hs));
        chk("stallM", stallM, on && !ex && mem);
        chk("stallW", stallW, on && !ex && mem);
        chk("flushD", flushD, ex);
        chk("flushE", flushE, ex || (on && (lw || br) && !dv && !mem));
        chk("flushM", flushM, ex || (on && hs));
        chk("flushW", flushW, ex);
    endtask

    task automatic settle();
        @(negedge clk);
        checkAll();
    endtask

    task automatic tick();
        bit start, pend;
        @(posedge clk);
        start = divStartExp();
        pend = !rst && (exceptM || mPend) && d_stall;
        if (rst || exFlush()) begin
            mBusy = 0;
            mDone = 0;
            mBusyCycles = 0;
        end else if (mDone) begin
            mDone = 0;
        end else if (mBusy) begin
            if (div_done) begin
                mBusy = 0;
                mDone = 1;
            end else if (mBusyCycles == LIMIT) begin
                mBusy = 0;
            end else begin
                mBusyCycles++;
            end
        end else if (start) begin
            mBusy = 1;
            mBusyCycles = 0;
        end
        mPend = pend;
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic clearInputs();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jalrD} = '0;
        {hiloreadE, hilowriteM, hilowriteW, divE, div_done, i_stall, d_stall, exceptM} = '0;
    endtask

    task automatic randomInputs();
        rsD = 5'($urandom_range(0, 3));
        rtD = 5'($urandom_range(0, 3));
        rsE = 5'($urandom_range(0, 3));
        rtE = 5'($urandom_range(0, 3));
        writeregE = 5'($urandom_range(0, 3));
        writeregM = 5'($urandom_range(0, 3));
        writeregW = 5'($urandom_range(0, 3));
        regwriteE = 1'($urandom_range(0, 1));
        regwriteM = 1'($urandom_range(0, 1));
        regwriteW = 1'($urandom_range(0, 1));
        memtoregE = $urandom_range(0, 3) == 0;
        memtoregM = $urandom_range(0, 3) == 0;
        branchD = $urandom_range(0, 3) == 0;
        jalrD = $urandom_range(0, 7) == 0;
        hiloreadE = $urandom_range(0, 3) == 0;
        hilowriteM = $urandom_range(0, 3) == 0;
        hilowriteW = $urandom_range(0, 3) == 0;
        divE = $urandom_range(0, 2) == 0;
        div_done = $urandom_range(0, 15) == 0;
        i_stall = $urandom_range(0, 5) == 0;
        d_stall = $urandom_range(0, 4) == 0;
        exceptM = $urandom_range(0, 23) == 0;
        rst = $urandom_range(0, 79) == 0;
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        i_stall = 1'b1;
        divE = 1'b1;
        memtoregE = 1'b1;
        #1;
        cyc();
        settle();
        chk("rst_stallE", stallE, 1'b0);
        tick();
        rst = 1'b0;
        clearInputs();
        cyc();

        // load-use: lw $2 in E, add $3,$2,$4 in D
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd2; rtE = 5'd2; rsD = 5'd2; rtD = 5'd4;
        settle();
        chk("lu_stallD", stallD, 1'b1);
        chk("lu_flushE", flushE, 1'b1);
        tick();
        clearInputs();
        memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd2; rsE = 5'd2;
        settle();
        chk("lu_fwdAE", forwardAE, 2'b10);
        tick();

        clearInputs();
        regwriteW = 1'b1; writeregW = 5'd5; rsE = 5'd5; rtE = 5'd5;
        settle();
        chk("w_fwdAE", forwardAE, 2'b01);
        tick();
        clearInputs();
        regwriteM = 1'b1; writeregM = 5'd0; rsE = 5'd0;
        settle();
        chk("r0_fwdAE", forwardAE, 2'b00);
        tick();

        // divide completing at cycle 33
        clearInputs();
        divE = 1'b1;
        settle();
        chk("div_start0", div_start, 1'b1);
        tick();
        for (int c = 1; c <= 33; c++) begin
            div_done = (c == 33);
            settle();
            chk("div_stallE", stallE, 1'b1);
            if (c == 1) chk("div_start1", div_start, 1'b0);
            tick();
        end
        div_done = 1'b0;
        settle();
        chk("div_done_stallE", stallE, 1'b0);
        tick();
        divE = 1'b0;
        cyc();

        // watchdog: no div_done, BUSY gives up and a still-present divE restarts
        divE = 1'b1;
        for (int c = 0; c <= LIMIT + 1; c++) cyc();
        settle();
        chk("wd_restart", div_start, 1'b1);
        tick();
        clearInputs();
        exceptM = 1'b1;
        cyc();

        // exception deferred behind 3 cycles of d_stall
        clearInputs();
        exceptM = 1'b1;
        d_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("exd_noflush", flushD, 1'b0);
            tick();
            exceptM = 1'b0;
        end
        d_stall = 1'b0;
        settle();
        chk("exd_flushW", flushW, 1'b1);
        tick();
        settle();
        chk("exd_cleared", flushM, 1'b0);
        tick();

        // exception during BUSY aborts; late div_done ignored
        divE = 1'b1;
        for (int c = 0; c < 6; c++) cyc();
        exceptM = 1'b1;
        settle();
        chk("exb_flushE", flushE, 1'b1);
        chk("exb_stallE", stallE, 1'b0);
        tick();
        clearInputs();
        div_done = 1'b1;
        cyc();
        div_done = 1'b0;
        cyc();

        // reset mid-BUSY, then a fresh start
        divE = 1'b1;
        for (int c = 0; c < 10; c++) cyc();
        rst = 1'b1;
        settle();
        chk("rstb_stallF", stallF, 1'b0);
        tick();
        rst = 1'b0;
        settle();
        chk("rstb_restart", div_start, 1'b1);
        tick();
        clearInputs();
        exceptM = 1'b1;
        cyc();

        // reset while an exception is pending
        clearInputs();
        exceptM = 1'b1; d_stall = 1'b1;
        cyc();
        exceptM = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; d_stall = 1'b0;
        settle();
        chk("rstp_noflush", flushD, 1'b0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            randomInputs();
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard.md
# pipeline_hazard

Hazard and stall arbiter for the five-stage MIPS core: it consumes the per-stage control bits produced by the pipeline controller and returns the stall/flush signals the controller's pipeline registers consume, plus operand and HI/LO forwarding selects for the datapath. It also runs the multi-cycle divide handshake and defers exception flushes across data-memory stalls.

## Interface
Parameters:
- DIV_MAX_CYCLES, 40, divide watchdog limit; BUSY longer than this forces IDLE.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- rsD, rtD, rsE, rtE  in  5  source register numbers in D and E
- writeregE, writeregM, writeregW  in  5  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  register-file write enables per stage
- memtoregE, memtoregM  in  1  load in E / M
- branchD, jalrD  in  1  D-stage compare/jump consumers of rs/rt
- hiloreadE, hilowriteM, hilowriteW  in  1  HI/LO read in E, writes in M/W
- divE  in  1  div/divu in E
- div_done  in  1  divider result valid, one-cycle pulse
- i_stall, d_stall  in  1  instruction/data memory not ready
- exceptM  in  1  exception or eret committing in M
- forwardAD, forwardBD  out  1  D compare operand from M result
- forwardAE, forwardBE  out  2  00 regfile, 01 W result, 10 M result
- forwardhiloE  out  2  00 HI/LO reg, 01 W, 10 M
- div_start  out  1  one-cycle divider start pulse
- stallF, stallD, stallE, stallM, stallW  out  1  stage hold
- flushD, flushE, flushM, flushW  out  1  stage bubble insert

## Operation
- E forwarding: M match (regwriteM, writeregM≠0, writeregM==rsE) → 10; else W match → 01; else 00. Same for rtE.
- D forwarding: forwardAD = rsD≠0 & rsD==writeregM & regwriteM; same for BD.
- Load-use: memtoregE & (rtE==rsD | rtE==rtD) → lwstall.
- Branch: (branchD|jalrD) & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})) → branchstall. Register 0 never matches.
- Divide FSM: IDLE, BUSY, DONE.
  - IDLE→BUSY when divE & ~stallE & ~flushE; div_start=1 that cycle.
  - BUSY: count cycles; div_done → DONE; count==DIV_MAX_CYCLES → IDLE.
  - DONE→IDLE next cycle (result latches into E); stallE released in DONE.
  - divstall = (state==IDLE & divE) | state==BUSY.
- Stall equations: stallF=stallD = lwstall|branchstall|divstall|memstall; stallE = divstall|memstall; stallM=stallW = memstall; memstall = i_stall|d_stall.
- flushE = (lwstall|branchstall) & ~divstall & ~memstall (bubble behind held D).
- Exceptions: exceptM & ~d_stall → flushD/E/M/W=1, all stalls 0, FSM→IDLE next cycle. exceptM & d_stall → set exc_pending; flushes asserted first cycle d_stall=0, then exc_pending clears.

## Timing
- Forwards, stalls, flushes combinational from inputs and registered state; same-cycle response.
- Registered: FSM state, cycle counter (6 bits), exc_pending.
- Reset: state IDLE, counter 0, exc_pending 0; while rst=1, all outputs 0.
- div_start exactly one cycle; divE held by stallE thereafter.
- exceptM during BUSY: abort, no DONE; late div_done in IDLE ignored.
- i_stall and d_stall together: single memstall, no double counting.
- rst asserted mid-BUSY or with exc_pending: both cleared next edge, no flush pulse emitted.

## Configuration
- HAZARD_HILO_FWD_EN defined: forwardhiloE = 10 if hilowriteM, else 01 if hilowriteW, else 00; no HI/LO stall.
- Undefined: forwardhiloE tied 00; hiloreadE & (hilowriteM|hilowriteW) asserts stallF/D/E and flushM until the write retires.

## Structure
- Shared package: forwarding select constants (FWD_RF, FWD_W, FWD_M), divide FSM state enum, DIV_MAX_CYCLES default.
- One sub-module: div_handshake (FSM, counter, div_start, divstall); rest is flat.

## Test plan
- lw $2 in E, add $3,$2,$4 in D → stallF=stallD=1, flushE=1 one cycle, then forwardAE=10 next cycle.
- add $5 in M, sub using $5 in E → forwardAE=10; same in W only → 01; writereg 0 → 00.
- divE=1, div_done at cycle 33 → div_start pulse cycle 0, stallE=1 cycles 0–33, DONE cycle 34, IDLE cycle 35.
- exceptM with d_stall=1 for 3 cycles → no flush cycles 0–2, flushD/E/M/W=1 cycle 3 only.
- exceptM during BUSY → all flushes same cycle, FSM IDLE next cycle, later div_done no effect.
- rst=1 during BUSY at cycle 10 → all outputs 0; after release, divE needs fresh start pulse.
